// File: rtl/arith_pipe_pkg.sv
// arith_pipe_pkg: shared constants and types for the arith_pipeline slice.
//   - MIPS opcode / funct encodings for the supported arithmetic/logic subset
//   - ALU operation codes (same numbering as alu32)
//   - immediate-select and destination-select enums used by the decoder
//   - F/EX stage-register layout (raw instruction fields)
package arith_pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;

  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_OR  = 3'd5;
  localparam logic [2:0] ALU_NOR = 3'd6;
  localparam logic [2:0] ALU_XOR = 3'd7;

  typedef enum logic [1:0] {IMM_REG, IMM_SEXT, IMM_ZEXT} imm_sel_e;
  typedef enum logic {DST_RT, DST_RD} rd_src_e;

  // F/EX register: the fetched instruction word, split into MIPS fields.
  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_t;

  // I-type immediate occupies the rd/shamt/funct bit positions.
  function automatic logic [15:0] imm_of(instr_t i);
    return {i.rd, i.shamt, i.funct};
  endfunction

endpackage

// File: rtl/arith_pipe_decode.sv
// arith_pipe_decode: combinational opcode/funct decoder.
//   opcode, funct -> alu_op, imm_sel (reg / sign-ext / zero-ext),
//   rd_src (rd for R-type, rt for I-type), we, illegal.
module arith_pipe_decode
  import arith_pipe_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output imm_sel_e   imm_sel,
  output rd_src_e    rd_src,
  output logic       we,
  output logic       illegal
);

  always_comb begin
    alu_op  = ALU_ADD;
    imm_sel = IMM_REG;
    rd_src  = DST_RD;
    we      = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        we = 1'b1;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          default: begin
            we      = 1'b0;
            illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin alu_op = ALU_ADD; imm_sel = IMM_SEXT; rd_src = DST_RT; we = 1'b1; end
      OP_ANDI: begin alu_op = ALU_AND; imm_sel = IMM_ZEXT; rd_src = DST_RT; we = 1'b1; end
      OP_ORI:  begin alu_op = ALU_OR;  imm_sel = IMM_ZEXT; rd_src = DST_RT; we = 1'b1; end
      OP_XORI: begin alu_op = ALU_XOR; imm_sel = IMM_ZEXT; rd_src = DST_RT; we = 1'b1; end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/arith_pipeline.sv
// arith_pipeline: 3-stage (F / EX / WB) MIPS arithmetic/logic pipeline.
//   clock, reset (sync, active-high), enable (0 = freeze all state)
//   imem_addr/imem_data : combinational instruction fetch (word address)
//   dbg_sel/dbg_data    : combinational regfile read port ($0 reads 0)
//   except  : sticky, set when an illegal instruction reaches EX
//   halted  : set once except is up and WB has drained
//   retired : saturating count of WB writes (including writes to $0)
module arith_pipeline
  import arith_pipe_pkg::*;
#(
  parameter int W     = 32,
  parameter int AW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [AW-3:0]    imem_addr,
  input  logic [31:0]      imem_data,
  input  logic [4:0]       dbg_sel,
  output logic [W-1:0]     dbg_data,
  output logic             except,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  logic [AW-1:0]    pc_q, pc_d;
  instr_t           fex_q, fex_d;
  logic [1:0]       vld_pipe_q, vld_pipe_d;  // [0] = F/EX valid, [1] = EX/WB valid
  logic [4:0]       wb_dst_q, wb_dst_d;
  logic [W-1:0]     wb_data_q, wb_data_d;
  logic             except_q, except_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [W-1:0]     rf_q [32];

  logic [2:0]          alu_op;
  imm_sel_e            imm_sel;
  rd_src_e             rd_src;
  logic                we, illegal;
  logic                wb_wr, ex_illegal, stop;
  logic signed [15:0]  imm_s;
  logic [W-1:0]        rs_val, rt_val, op_b, alu_res;

  arith_pipe_decode u_dec (
    .opcode  (fex_q.opcode),
    .funct   (fex_q.funct),
    .alu_op  (alu_op),
    .imm_sel (imm_sel),
    .rd_src  (rd_src),
    .we      (we),
    .illegal (illegal)
  );

  // A WB entry targeting $0 still retires but neither writes nor forwards.
  assign wb_wr      = vld_pipe_q[1] && (wb_dst_q != 5'd0);
  assign ex_illegal = vld_pipe_q[0] && illegal;

  // Operand read with WB->EX forwarding; distance-2 reads see the regfile.
  always_comb begin
    rs_val = (fex_q.rs == 5'd0) ? '0 : rf_q[fex_q.rs];
    rt_val = (fex_q.rt == 5'd0) ? '0 : rf_q[fex_q.rt];
    if (wb_wr && wb_dst_q == fex_q.rs) rs_val = wb_data_q;
    if (wb_wr && wb_dst_q == fex_q.rt) rt_val = wb_data_q;
    imm_s = $signed(imm_of(fex_q));
    case (imm_sel)
      IMM_SEXT: op_b = W'(imm_s);
      IMM_ZEXT: op_b = W'(imm_of(fex_q));
      default:  op_b = rt_val;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD: alu_res = rs_val + op_b;
      ALU_SUB: alu_res = rs_val - op_b;
      ALU_AND: alu_res = rs_val & op_b;
      ALU_OR:  alu_res = rs_val | op_b;
      ALU_NOR: alu_res = ~(rs_val | op_b);
      ALU_XOR: alu_res = rs_val ^ op_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    fex_d      = fex_q;
    vld_pipe_d = vld_pipe_q;
    wb_dst_d   = wb_dst_q;
    wb_data_d  = wb_data_q;
    except_d   = except_q;
    halted_d   = halted_q;
    retired_d  = retired_q;
    stop       = 1'b0;
    if (enable) begin
      // Fetch stops for good once an illegal instruction is seen; the
      // instruction behind it in F/EX is squashed.
      stop          = except_q || ex_illegal;
      vld_pipe_d[1] = vld_pipe_q[0] && we && !illegal;
      wb_dst_d      = (rd_src == DST_RD) ? fex_q.rd : fex_q.rt;
      wb_data_d     = alu_res;
      vld_pipe_d[0] = !stop;
      if (!stop) begin
        fex_d = imem_data;
        pc_d  = pc_q + AW'(4);
      end
      except_d = except_q || ex_illegal;
      halted_d = halted_q || (except_q && !vld_pipe_q[1]);
      if (vld_pipe_q[1] && retired_q != '1) retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q       <= '0;
      fex_q      <= '0;
      vld_pipe_q <= '0;
      wb_dst_q   <= '0;
      wb_data_q  <= '0;
      except_q   <= 1'b0;
      halted_q   <= 1'b0;
      retired_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      fex_q      <= fex_d;
      vld_pipe_q <= vld_pipe_d;
      wb_dst_q   <= wb_dst_d;
      wb_data_q  <= wb_data_d;
      except_q   <= except_d;
      halted_q   <= halted_d;
      retired_q  <= retired_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (enable && wb_wr) begin
      rf_q[wb_dst_q] <= wb_data_q;
    end
  end

  assign imem_addr = pc_q[AW-1:2];
  assign dbg_data  = (dbg_sel == 5'd0) ? '0 : rf_q[dbg_sel];
  assign except    = except_q;
  assign halted    = halted_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_arith_pipeline.sv
module tb_arith_pipeline;

  localparam logic [31:0] FILLER = 32'h0000_0020;  // add $0,$0,$0

  logic        clock, reset, enable;
  logic [29:0] imem_addr;
  logic [31:0] imem_data;
  logic [4:0]  dbg_sel;
  logic [31:0] dbg_data;
  logic        except, halted;
  logic [15:0] retired;
  logic [31:0] imem [16];

  logic [1:0]  imem_addr2;
  logic [31:0] imem_data2;
  logic [4:0]  dbg_sel2;
  logic [15:0] dbg_data2;
  logic        except2, halted2;
  logic [1:0]  retired2;
  logic [31:0] imem2 [4];

  int n_tests, n_fail;

  arith_pipeline #(.W(32), .AW(32), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data),
    .except(except), .halted(halted), .retired(retired)
  );

  arith_pipeline #(.W(16), .AW(4), .CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .enable(enable),
    .imem_addr(imem_addr2), .imem_data(imem_data2),
    .dbg_sel(dbg_sel2), .dbg_data(dbg_data2),
    .except(except2), .halted(halted2), .retired(retired2)
  );

  assign imem_data  = imem[imem_addr[3:0]];
  assign imem_data2 = imem2[imem_addr2];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0][31:0] prog;
    logic [7:0]       ncyc;
    logic [2:0][4:0]  sel;
    logic [2:0][31:0] expv;
    logic [15:0]      ret;
    logic             exc;
    logic             hlt;
    logic [31:0]      addr;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(logic [5:0] fn, logic [4:0] rd, logic [4:0] rs, logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic vec_t mk(logic [31:0] i0, logic [31:0] i1, logic [31:0] i2, logic [7:0] nc,
                              logic [4:0] s0, logic [4:0] s1, logic [4:0] s2,
                              logic [31:0] e0, logic [31:0] e1, logic [31:0] e2,
                              logic [15:0] ret, logic exc, logic hlt, logic [31:0] addr);
    vec_t v;
    v.prog[0] = i0; v.prog[1] = i1; v.prog[2] = i2;
    v.ncyc = nc;
    v.sel[0] = s0;  v.sel[1] = s1;  v.sel[2] = s2;
    v.expv[0] = e0; v.expv[1] = e1; v.expv[2] = e2;
    v.ret = ret; v.exc = exc; v.hlt = hlt; v.addr = addr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    enable = 1'b1;
    repeat (n) step();
    enable = 1'b0;
  endtask

  task automatic load(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] i2);
    for (int i = 0; i < 16; i++) imem[i] = FILLER;
    imem[0] = i0; imem[1] = i1; imem[2] = i2;
  endtask

  task automatic dbg(input string name, input logic [4:0] sel, input logic [31:0] exp);
    dbg_sel = sel;
    #1;
    check(name, dbg_data, exp);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1'b1; enable = 1'b0; dbg_sel = '0; dbg_sel2 = '0;
    imem2[0] = enc_i(6'h08, 0, 1, 16'h0001);
    imem2[1] = enc_i(6'h08, 0, 2, 16'h0002);
    imem2[2] = enc_i(6'h08, 0, 3, 16'h0003);
    imem2[3] = enc_i(6'h08, 0, 4, 16'hFFFC);

    vecs[0] = mk(enc_i(6'h08,0,1,16'h0005), enc_i(6'h08,0,2,16'hFFFD), FILLER, 4,
                 1, 2, 0, 32'd5, 32'hFFFF_FFFD, 32'd0, 2, 0, 0, 4);
    vecs[1] = mk(enc_i(6'h08,0,1,16'h0007), enc_r(6'h20,2,1,1), enc_r(6'h22,3,2,1), 5,
                 1, 2, 3, 32'd7, 32'd14, 32'd7, 3, 0, 0, 5);
    vecs[2] = mk(enc_i(6'h0D,0,4,16'hFFFF), enc_i(6'h0C,4,5,16'h00F0), enc_r(6'h27,6,5,0), 5,
                 4, 5, 6, 32'h0000_FFFF, 32'h0000_00F0, 32'hFFFF_FF0F, 3, 0, 0, 5);
    vecs[3] = mk(enc_i(6'h08,0,1,16'h0001), 32'hFC00_0000, enc_i(6'h08,0,2,16'h0009), 6,
                 1, 2, 0, 32'd1, 32'd0, 32'd0, 1, 1, 1, 2);
    vecs[4] = mk(enc_i(6'h08,0,7,16'h0F0F), enc_i(6'h0E,7,8,16'hFFFF), enc_r(6'h25,9,7,8), 5,
                 7, 8, 9, 32'h0000_0F0F, 32'h0000_F0F0, 32'h0000_FFFF, 3, 0, 0, 5);
    vecs[5] = mk(enc_i(6'h08,0,1,16'hFFFF), enc_r(6'h20,2,1,1), enc_r(6'h26,3,2,1), 5,
                 1, 2, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 3, 0, 0, 5);
    vecs[6] = mk(enc_i(6'h08,0,0,16'h0005), enc_r(6'h20,1,0,0), enc_i(6'h08,0,2,16'h0008), 5,
                 0, 1, 2, 32'd0, 32'd0, 32'd8, 3, 0, 0, 5);
    vecs[7] = mk(enc_i(6'h08,0,1,16'h0002), enc_r(6'h21,3,1,1), FILLER, 6,
                 1, 3, 0, 32'd2, 32'd0, 32'd0, 1, 1, 1, 2);

    // Reset state
    load(FILLER, FILLER, FILLER);
    do_reset();
    check("rst imem_addr", 32'(imem_addr), 32'd0);
    check("rst except", 32'(except), 32'd0);
    check("rst halted", 32'(halted), 32'd0);
    check("rst retired", 32'(retired), 32'd0);
    dbg("rst dbg$5", 5, 32'd0);

    // Table-driven programs
    for (int v = 0; v < 8; v++) begin
      load(vecs[v].prog[0], vecs[v].prog[1], vecs[v].prog[2]);
      do_reset();
      run(int'(vecs[v].ncyc));
      for (int k = 0; k < 3; k++)
        dbg($sformatf("v%0d dbg$%0d", v, vecs[v].sel[k]), vecs[v].sel[k], vecs[v].expv[k]);
      check($sformatf("v%0d retired", v), 32'(retired), 32'(vecs[v].ret));
      check($sformatf("v%0d except", v), 32'(except), 32'(vecs[v].exc));
      check($sformatf("v%0d halted", v), 32'(halted), 32'(vecs[v].hlt));
      check($sformatf("v%0d imem_addr", v), 32'(imem_addr), vecs[v].addr);
    end

    // Illegal in EX while disabled: nothing moves until enable returns
    load(enc_i(6'h08,0,1,16'h0001), 32'hFC00_0000, enc_i(6'h08,0,2,16'h0009));
    do_reset();
    run(2);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("exdis%0d except", c), 32'(except), 32'd0);
      check($sformatf("exdis%0d addr", c), 32'(imem_addr), 32'd2);
      check($sformatf("exdis%0d retired", c), 32'(retired), 32'd0);
    end
    run(1);
    check("ex+1 except", 32'(except), 32'd1);
    check("ex+1 halted", 32'(halted), 32'd0);
    check("ex+1 retired", 32'(retired), 32'd1);
    run(1);
    check("ex+2 halted", 32'(halted), 32'd1);
    run(3);
    check("ex+5 addr frozen", 32'(imem_addr), 32'd2);
    check("ex+5 retired", 32'(retired), 32'd1);

    // enable=0 mid-stream, then reset while an instruction is in EX
    load(enc_i(6'h08,0,1,16'h0005), enc_i(6'h08,0,2,16'h0006), FILLER);
    do_reset();
    run(2);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("dis%0d addr", c), 32'(imem_addr), 32'd2);
      check($sformatf("dis%0d retired", c), 32'(retired), 32'd0);
      dbg($sformatf("dis%0d dbg$1", c), 1, 32'd0);
    end
    run(1);
    dbg("resume dbg$1", 1, 32'd5);
    check("resume retired", 32'(retired), 32'd1);
    enable = 1'b0;
    do_reset();
    check("midrst addr", 32'(imem_addr), 32'd0);
    check("midrst retired", 32'(retired), 32'd0);
    check("midrst except", 32'(except), 32'd0);
    check("midrst halted", 32'(halted), 32'd0);
    dbg("midrst dbg$1", 1, 32'd0);
    dbg("midrst dbg$2", 2, 32'd0);

    // Narrow instance: PC wrap and counter saturation
    do_reset();
    run(3);
    check("n addr3", 32'(imem_addr2), 32'd3);
    run(1);
    check("n wrap addr0", 32'(imem_addr2), 32'd0);
    check("n retired c4", 32'(retired2), 32'd2);
    run(3);
    check("n retired sat", 32'(retired2), 32'd3);
    check("n except", 32'(except2), 32'd0);
    dbg_sel2 = 5'd4;
    #1;
    check("n dbg$4", 32'(dbg_data2), 32'h0000_FFFC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
